// File: rtl/trig_shift_leak_pkg.sv
// Shared types and helpers for the trigger-and-activity benchmark block.
package trig_shift_leak_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } tsl_state_e;

    localparam logic [127:0] TSL_TRIG_VAL_DEF = 128'h00112233_44556677_8899aabb_ccddeeff;

    // Taps are zero-extended to this width before the parity reduction.
    localparam int TSL_TAP_MAX = 1024;

    function automatic logic tsl_masked_parity(input logic [TSL_TAP_MAX-1:0] a,
                                               input logic [TSL_TAP_MAX-1:0] b);
        return ^(a & b);
    endfunction

endpackage

// File: rtl/trig_shift_leak_if.sv
// Cipher-state observation bus and exposed activity outputs of trig_shift_leak.
interface trig_shift_leak_if #(
    parameter int DATA_W = 128,
    parameter int NCH    = 8,
    parameter int SHR_W  = 8,
    parameter int CNT_W  = 16
);
    logic                    state_vld;
    logic [DATA_W-1:0]       state;
    logic [NCH*DATA_W-1:0]   rk;
    logic                    trig_active;
    logic [NCH-1:0]          en;
    logic [NCH*SHR_W-1:0]    shreg;
    logic [NCH*CNT_W-1:0]    rot_cnt;

    modport master (
        output state_vld, state, rk,
        input  trig_active, en, shreg, rot_cnt
    );

    modport slave (
        input  state_vld, state, rk,
        output trig_active, en, shreg, rot_cnt
    );
endinterface

// File: rtl/trig_shift_leak_channel.sv
// One round-key channel: masked parity, registered enable, rotating shift register
// and saturating rotation counter.
module tsl_channel
    import trig_shift_leak_pkg::*;
#(
    parameter int               TAP_W    = 8,
    parameter int               SHR_W    = 8,
    parameter logic [SHR_W-1:0] SHR_INIT = {SHR_W/2{2'b10}},
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gate,
    input  logic [TAP_W-1:0] state_tap,
    input  logic [TAP_W-1:0] rk_tap,
    output logic             en,
    output logic [SHR_W-1:0] shreg,
    output logic [CNT_W-1:0] rot_cnt
);
    logic             parity_s;
    logic             rot_s;
    logic             en_r;
    logic [SHR_W-1:0] shreg_r;
    logic [CNT_W-1:0] cnt_r;

    assign parity_s = tsl_masked_parity(TSL_TAP_MAX'(state_tap), TSL_TAP_MAX'(rk_tap));
    assign rot_s    = gate & parity_s;

    // Rotate right and count on every gated parity hit; otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_r    <= 1'b0;
            shreg_r <= SHR_INIT;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            en_r <= rot_s;
            if (rot_s) begin
                shreg_r <= {shreg_r[0], shreg_r[SHR_W-1:1]};
                if (cnt_r != {CNT_W{1'b1}}) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end else begin
                shreg_r <= shreg_r;
                cnt_r   <= cnt_r;
            end
        end
    end

    assign en      = en_r;
    assign shreg   = shreg_r;
    assign rot_cnt = cnt_r;

endmodule

// File: rtl/trig_shift_leak.sv
// Trigger FSM watching the state bus; once armed, gates per-channel rotation
// for ACTIVE_CYC cycles (or until reset when ACTIVE_CYC is 0).
module trig_shift_leak
    import trig_shift_leak_pkg::*;
#(
    parameter int                DATA_W     = 128,
    parameter int                NCH        = 8,
    parameter int                TAP_W      = 8,
    parameter int                SHR_W      = 8,
    parameter logic [SHR_W-1:0]  SHR_INIT   = {SHR_W/2{2'b10}},
    parameter logic [DATA_W-1:0] TRIG_VAL   = DATA_W'(TSL_TRIG_VAL_DEF),
    parameter int                TRIG_HITS  = 1,
    parameter int                ACTIVE_CYC = 0,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    trig_shift_leak_if.slave  bus
);
    localparam logic [7:0]  HITS_TGT = 8'(TRIG_HITS);
    localparam logic [31:0] ACT_LOAD = (ACTIVE_CYC != 0) ? 32'(ACTIVE_CYC - 1) : 32'd0;

    tsl_state_e  state_r;
    logic [7:0]  hit_cnt_r;
    logic [31:0] act_cnt_r;
    logic        trig_active_r;
    logic        match_s;
    logic [7:0]  hit_nxt_s;
    logic        gate_s;

    logic [NCH-1:0]       en_s;
    logic [NCH*SHR_W-1:0] shreg_s;
    logic [NCH*CNT_W-1:0] cnt_s;

    assign match_s   = (bus.state == TRIG_VAL);
    assign hit_nxt_s = hit_cnt_r + 8'd1;
    assign gate_s    = (state_r == ST_ACTIVE) && bus.state_vld;

    // Arm on the TRIG_HITS-th consecutive valid match; count down the active window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            hit_cnt_r     <= 8'd0;
            act_cnt_r     <= 32'd0;
            trig_active_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.state_vld) begin
                        if (match_s && (hit_nxt_s == HITS_TGT)) begin
                            state_r       <= ST_ACTIVE;
                            hit_cnt_r     <= 8'd0;
                            act_cnt_r     <= ACT_LOAD;
                            trig_active_r <= 1'b1;
                        end else if (match_s) begin
                            hit_cnt_r <= hit_nxt_s;
                        end else begin
                            hit_cnt_r <= 8'd0;
                        end
                    end else begin
                        hit_cnt_r <= hit_cnt_r;
                    end
                end
                ST_ACTIVE: begin
                    // A zero window length means the block stays armed until reset.
                    if (ACTIVE_CYC != 0) begin
                        if (act_cnt_r == 32'd0) begin
                            state_r       <= ST_IDLE;
                            hit_cnt_r     <= 8'd0;
                            trig_active_r <= 1'b0;
                        end else begin
                            act_cnt_r <= act_cnt_r - 32'd1;
                        end
                    end else begin
                        act_cnt_r <= act_cnt_r;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    hit_cnt_r     <= 8'd0;
                    act_cnt_r     <= 32'd0;
                    trig_active_r <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tsl_channel #(
            .TAP_W    (TAP_W),
            .SHR_W    (SHR_W),
            .SHR_INIT (SHR_INIT),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .gate      (gate_s),
            .state_tap (bus.state[TAP_W-1:0]),
            .rk_tap    (bus.rk[i*DATA_W +: TAP_W]),
            .en        (en_s[i]),
            .shreg     (shreg_s[i*SHR_W +: SHR_W]),
            .rot_cnt   (cnt_s[i*CNT_W +: CNT_W])
        );
    end

    assign bus.trig_active = trig_active_r;
    assign bus.en          = en_s;
    assign bus.shreg       = shreg_s;
    assign bus.rot_cnt     = cnt_s;

endmodule

// File: tb/tb_trig_shift_leak.sv
// Directed scoreboard bench for trig_shift_leak across three parameter sets.
module tb_trig_shift_leak;

    typedef struct {
        string          tag;
        logic           trig;
        logic [15:0]    en;
        logic [127:0]   sh;
        logic [255:0]   cnt;
    } exp_t;

    localparam logic [127:0] TV  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [31:0]  TVC = 32'hCAFE_F00D;
    localparam logic [63:0]  SH8 = 64'hAAAA_AAAA_AAAA_AAAA;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always #5 clk = ~clk;

    trig_shift_leak_if #(.DATA_W(128), .NCH(8), .SHR_W(8), .CNT_W(16)) bus_a ();
    trig_shift_leak_if #(.DATA_W(128), .NCH(8), .SHR_W(8), .CNT_W(16)) bus_b ();
    trig_shift_leak_if #(.DATA_W(32),  .NCH(3), .SHR_W(4), .CNT_W(2))  bus_c ();

    trig_shift_leak u_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));

    trig_shift_leak #(.TRIG_HITS(3), .ACTIVE_CYC(4)) u_b (
        .clk(clk), .rst(rst_b), .bus(bus_b.slave)
    );

    trig_shift_leak #(
        .DATA_W(32), .NCH(3), .TAP_W(4), .SHR_W(4), .CNT_W(2),
        .TRIG_VAL(32'hCAFE_F00D), .TRIG_HITS(1), .ACTIVE_CYC(0)
    ) u_c (
        .clk(clk), .rst(rst_c), .bus(bus_c.slave)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp(input exp_t x, input logic t, input logic [15:0] e,
                       input logic [127:0] sh, input logic [255:0] cnt);
        chk({x.tag, ".trig"},  256'(t),   256'(x.trig));
        chk({x.tag, ".en"},    256'(e),   256'(x.en));
        chk({x.tag, ".shreg"}, 256'(sh),  256'(x.sh));
        chk({x.tag, ".cnt"},   cnt,       x.cnt);
    endtask

    task automatic step_a(input logic r, input logic v, input logic [127:0] st,
                          input logic [1023:0] rk, input string tag, input logic t,
                          input logic [7:0] e, input logic [63:0] sh, input logic [127:0] cnt);
        exp_t x;
        @(negedge clk);
        rst_a = r; bus_a.state_vld = v; bus_a.state = st; bus_a.rk = rk;
        x.tag = tag; x.trig = t; x.en = 16'(e); x.sh = 128'(sh); x.cnt = 256'(cnt);
        q_a.push_back(x);
    endtask

    task automatic step_b(input logic r, input logic v, input logic [127:0] st,
                          input logic [1023:0] rk, input string tag, input logic t,
                          input logic [7:0] e, input logic [63:0] sh, input logic [127:0] cnt);
        exp_t x;
        @(negedge clk);
        rst_b = r; bus_b.state_vld = v; bus_b.state = st; bus_b.rk = rk;
        x.tag = tag; x.trig = t; x.en = 16'(e); x.sh = 128'(sh); x.cnt = 256'(cnt);
        q_b.push_back(x);
    endtask

    task automatic step_c(input logic r, input logic v, input logic [31:0] st,
                          input logic [95:0] rk, input string tag, input logic t,
                          input logic [2:0] e, input logic [11:0] sh, input logic [5:0] cnt);
        exp_t x;
        @(negedge clk);
        rst_c = r; bus_c.state_vld = v; bus_c.state = st; bus_c.rk = rk;
        x.tag = tag; x.trig = t; x.en = 16'(e); x.sh = 128'(sh); x.cnt = 256'(cnt);
        q_c.push_back(x);
    endtask

    // Monitors: one output sample per issued vector, taken just after the edge.
    exp_t ra, rb, rc;
    always begin
        @(posedge clk);
        #1;
        if (q_a.size() != 0) begin
            ra = q_a.pop_front();
            cmp(ra, bus_a.trig_active, 16'(bus_a.en), 128'(bus_a.shreg), 256'(bus_a.rot_cnt));
        end
        if (q_b.size() != 0) begin
            rb = q_b.pop_front();
            cmp(rb, bus_b.trig_active, 16'(bus_b.en), 128'(bus_b.shreg), 256'(bus_b.rot_cnt));
        end
        if (q_c.size() != 0) begin
            rc = q_c.pop_front();
            cmp(rc, bus_c.trig_active, 16'(bus_c.en), 128'(bus_c.shreg), 256'(bus_c.rot_cnt));
        end
    end

    logic [1023:0] rk_a1, rk_a3, rk_a4;
    logic [95:0]   rk_c1, rk_c2;

    initial begin
        bus_a.state_vld = 1'b0; bus_a.state = '0; bus_a.rk = '0;
        bus_b.state_vld = 1'b0; bus_b.state = '0; bus_b.rk = '0;
        bus_c.state_vld = 1'b0; bus_c.state = '0; bus_c.rk = '0;

        rk_a1 = '0; rk_a1[7:0] = 8'h01;
        rk_a3 = '0; rk_a3[7:0] = 8'h01; rk_a3[135:128] = 8'h03; rk_a3[263:256] = 8'h02;
        rk_a4 = '0; rk_a4[15:0] = 16'h0101;
        rk_c1 = {32'h0000_0010, 32'h0000_0002, 32'h0000_0001};
        rk_c2 = {32'h0000_0014, 32'h0000_0002, 32'h0000_0001};

        // Defaults: arm on first match, rotation, reset mid-window, re-arm, tap masking.
        step_a(1'b0, 1'b0, 128'h0,   rk_a1, "a_rst",    1'b0, 8'h00, SH8, 128'h0);
        step_a(1'b1, 1'b1, TV,       rk_a1, "a_arm",    1'b1, 8'h00, SH8, 128'h0);
        step_a(1'b1, 1'b1, 128'h01,  rk_a1, "a_rot1",   1'b1, 8'h01, 64'hAAAA_AAAA_AAAA_AA55, 128'h1);
        step_a(1'b1, 1'b1, 128'h01,  rk_a3, "a_rot2",   1'b1, 8'h03, 64'hAAAA_AAAA_AAAA_55AA, 128'h0001_0002);
        step_a(1'b1, 1'b0, 128'h01,  rk_a3, "a_novld",  1'b1, 8'h00, 64'hAAAA_AAAA_AAAA_55AA, 128'h0001_0002);
        step_a(1'b1, 1'b1, 128'h03,  rk_a3, "a_mix",    1'b1, 8'h05, 64'hAAAA_AAAA_AA55_5555, 128'h0001_0001_0003);
        step_a(1'b0, 1'b1, 128'h03,  rk_a3, "a_midrst", 1'b0, 8'h00, SH8, 128'h0);
        step_a(1'b1, 1'b1, 128'h03,  rk_a3, "a_idle",   1'b0, 8'h00, SH8, 128'h0);
        step_a(1'b1, 1'b1, TV,       rk_a1, "a_rearm",  1'b1, 8'h00, SH8, 128'h0);
        step_a(1'b1, 1'b1, 128'h01,  rk_a1, "a_rot3",   1'b1, 8'h01, 64'hAAAA_AAAA_AAAA_AA55, 128'h1);
        step_a(1'b1, 1'b1, 128'h101, rk_a4, "a_tap",    1'b1, 8'h01, SH8, 128'h2);

        // TRIG_HITS=3, ACTIVE_CYC=4: hit counting, gap hold, 4-cycle window, re-arm after exit.
        step_b(1'b0, 1'b0, 128'h0,  rk_a1, "b_rst",  1'b0, 8'h00, SH8, 128'h0);
        step_b(1'b1, 1'b1, TV,      rk_a1, "b_m1",   1'b0, 8'h00, SH8, 128'h0);
        step_b(1'b1, 1'b1, TV,      rk_a1, "b_m2",   1'b0, 8'h00, SH8, 128'h0);
        step_b(1'b1, 1'b1, 128'h5,  rk_a1, "b_mis",  1'b0, 8'h00, SH8, 128'h0);
        step_b(1'b1, 1'b1, TV,      rk_a1, "b_m3",   1'b0, 8'h00, SH8, 128'h0);
        step_b(1'b1, 1'b0, TV,      rk_a1, "b_gap",  1'b0, 8'h00, SH8, 128'h0);
        step_b(1'b1, 1'b1, TV,      rk_a1, "b_m4",   1'b0, 8'h00, SH8, 128'h0);
        step_b(1'b1, 1'b1, TV,      rk_a1, "b_arm",  1'b1, 8'h00, SH8, 128'h0);
        step_b(1'b1, 1'b1, 128'h01, rk_a1, "b_w1",   1'b1, 8'h01, 64'hAAAA_AAAA_AAAA_AA55, 128'h1);
        step_b(1'b1, 1'b1, 128'h01, rk_a1, "b_w2",   1'b1, 8'h01, SH8, 128'h2);
        step_b(1'b1, 1'b1, 128'h01, rk_a1, "b_w3",   1'b1, 8'h01, 64'hAAAA_AAAA_AAAA_AA55, 128'h3);
        step_b(1'b1, 1'b1, 128'h01, rk_a1, "b_w4",   1'b0, 8'h01, SH8, 128'h4);
        step_b(1'b1, 1'b1, TV,      rk_a1, "b_post", 1'b0, 8'h00, SH8, 128'h4);
        step_b(1'b1, 1'b1, TV,      rk_a1, "b_r2",   1'b0, 8'h00, SH8, 128'h4);
        step_b(1'b1, 1'b1, TV,      rk_a1, "b_r3",   1'b1, 8'h00, SH8, 128'h4);
        step_b(1'b1, 1'b1, 128'h01, rk_a1, "b_r4",   1'b1, 8'h01, 64'hAAAA_AAAA_AAAA_AA55, 128'h5);

        // Narrow build: channel slicing, 4-bit taps, 4-bit shregs, 2-bit saturating counters.
        step_c(1'b0, 1'b0, 32'h0,  rk_c1, "c_rst", 1'b0, 3'b000, 12'hAAA, 6'h00);
        step_c(1'b1, 1'b1, TVC,    rk_c1, "c_arm", 1'b1, 3'b000, 12'hAAA, 6'h00);
        step_c(1'b1, 1'b1, 32'h13, rk_c1, "c_r1",  1'b1, 3'b011, 12'hA55, 6'h05);
        step_c(1'b1, 1'b1, 32'h13, rk_c1, "c_r2",  1'b1, 3'b011, 12'hAAA, 6'h0A);
        step_c(1'b1, 1'b1, 32'h13, rk_c1, "c_r3",  1'b1, 3'b011, 12'hA55, 6'h0F);
        step_c(1'b1, 1'b1, 32'h13, rk_c1, "c_r4",  1'b1, 3'b011, 12'hAAA, 6'h0F);
        step_c(1'b1, 1'b1, 32'h13, rk_c1, "c_r5",  1'b1, 3'b011, 12'hA55, 6'h0F);
        step_c(1'b1, 1'b1, 32'h4,  rk_c2, "c_ch2", 1'b1, 3'b100, 12'h555, 6'h1F);

        repeat (3) @(negedge clk);
        if ((q_a.size() + q_b.size() + q_c.size()) != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending samples expected 0",
                     q_a.size() + q_b.size() + q_c.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trig_shift_leak.md
# trig_shift_leak

Parametrised trigger-and-activity benchmark block for the AES regression designs. It watches the cipher state bus for a programmable plaintext pattern, arms after a configurable number of matching samples, then rotates one shift register per round-key channel whenever a masked state/round-key parity bit is 1. It generalises the fixed 8-channel, always-armed block: channel count, widths, hit count and active window are parameters. All internal activity is exposed on outputs so that detection and flattening tools can be checked against a known ground truth.

## Interface
- DATA_W, 128, width of state and of each round key
- NCH, 8, number of round-key channels (1..16)
- TAP_W, 8, low-order bits of state/rk used in parity (1..DATA_W)
- SHR_W, 8, shift-register width per channel (even, ≥2)
- SHR_INIT, {SHR_W/2{2'b10}}, shift-register reset value (8'hAA at default)
- TRIG_VAL, 128'h00112233_44556677_8899aabb_ccddeeff, trigger pattern (DATA_W bits)
- TRIG_HITS, 1, number of consecutive valid matches needed to arm (1..255)
- ACTIVE_CYC, 0, cycles spent ACTIVE before returning to IDLE; 0 = until reset
- CNT_W, 16, width of per-channel rotation counters
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset: one clock; synchronous, active-low
- state_vld  in  1  state bus holds a valid sample this cycle
- state  in  DATA_W  cipher state
- rk  in  NCH*DATA_W  round keys, channel i at [i*DATA_W +: DATA_W]
- trig_active  out  1  FSM in ACTIVE
- en  out  NCH  registered per-channel rotate enable
- shreg  out  NCH*SHR_W  shift registers, channel i at [i*SHR_W +: SHR_W]
- rot_cnt  out  NCH*CNT_W  saturating rotation count per channel

## Operation
- FSM states: IDLE, ACTIVE. Internal hit_cnt (8 bit), act_cnt (32 bit).
- IDLE: on state_vld with state==TRIG_VAL, hit_cnt increments; when the incremented value reaches TRIG_HITS, go ACTIVE and clear hit_cnt. A state_vld with a mismatch clears hit_cnt. No state_vld: hit_cnt holds.
- ACTIVE entry: act_cnt loads ACTIVE_CYC-1 (when ACTIVE_CYC≠0). Each ACTIVE cycle act_cnt decrements. At act_cnt==0, return IDLE, hit_cnt=0. ACTIVE_CYC=0: no exit except reset.
- Matches while ACTIVE are ignored; the window is not extended.
- Per channel i: p_i = XOR-reduce(state[TAP_W-1:0] & rk_i[TAP_W-1:0]). g_i = ACTIVE && state_vld && p_i.
- On each edge: en[i] <= g_i; if g_i, shreg_i <= {shreg_i[0], shreg_i[SHR_W-1:1]} (rotate right) and rot_cnt_i increments, saturating at all ones.
- IDLE: en forced 0; shregs and counters hold. Returning to IDLE does not reset shregs or rot_cnt.
- Reset (rst==0 at an edge, any state, mid-window included): IDLE, hit_cnt=0, trig_active=0, en=0, shreg=SHR_INIT per channel, rot_cnt=0.

## Timing
- Trigger: matching sample at edge N (the TRIG_HITS-th one) -> trig_active=1 after edge N. That sample's cycle does not rotate. Rotation uses inputs from cycle N+1 onward.
- en, shreg and rot_cnt all update on the same edge from the same-cycle inputs: 1-cycle latency, no additional pipelining.
- Window: exactly ACTIVE_CYC cycles with trig_active=1. Rotation is possible on each of them.
- Last ACTIVE cycle still rotates. trig_active=0 after the exit edge.
- A match on the cycle after exit counts toward re-arming.

## Structure
- Package trig_shift_leak_pkg: FSM state enum, default TRIG_VAL constant, masked-parity function.
- Sub-module tsl_channel, generated NCH times. It holds the parity, en register, shreg and rot_cnt; inputs are gate, state tap, rk tap. The top holds the FSM, hit_cnt and act_cnt.

## Test plan
- Defaults. Reset, then state=TRIG_VAL with vld, then rk0 low byte=0x01 with state low byte 0x01 (other rk=0) -> trig_active=1 after the first edge. Next edge: en=8'h01, shreg0=8'h55, rot_cnt0=1, other channels stay 8'hAA.
- TRIG_HITS=3. Match, match, mismatch, then 3 matches -> arms only on the 6th sample. A gap without vld between matches does not break the count.
- ACTIVE_CYC=4 with parity 1 continuously -> exactly 4 rotations. shreg0 returns to 8'hAA (even count), rot_cnt0=4, then trig_active=0 and en=0.
- CNT_W=2, active 5 rotating cycles -> rot_cnt saturates at 3. The shreg keeps rotating.
- Reset asserted mid-window -> next cycle all outputs at reset values. A later match re-arms normally.
- NCH=3, TAP_W=4, DATA_W=32, SHR_W=4 -> channel slicing correct, shreg init 4'hA. Parity ignores tap bits ≥4.
